// File: rtl/d_issue_ctrl.sv
// Decode-stage issue controller: per-register in-flight write scoreboard for RAW/WAW
// blocking, plus branch serialisation with a resolve timeout and a one-cycle flush.
module d_issue_ctrl #(
    parameter int CNT_W      = 2,
    parameter int BR_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fd_valid,
    input  logic [4:0]  dec_read_sel1,
    input  logic [4:0]  dec_read_sel2,
    input  logic        dec_uses_rs1,
    input  logic        dec_uses_rs2,
    input  logic [4:0]  dec_write_sel,
    input  logic        dec_is_wb,
    input  logic        dec_is_branch,
    input  logic        a_ready,
    input  logic        w_regfile,
    input  logic [4:0]  sel_regfile,
    input  logic        br_resolve,
    input  logic        br_taken,
    output logic        d_issue,
    output logic        d_stall,
    output logic        d_flush,
    output logic [31:0] busy_mask,
    output logic [1:0]  ctrl_state,
    output logic        sb_err
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        BR_WAIT = 2'b01,
        FLUSH   = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam int               TMO_W    = $clog2(BR_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(BR_TIMEOUT);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q [32];
    logic [CNT_W-1:0]  cnt_d [32];
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              flush_q, flush_d;
    logic              err_q, err_d;

    logic              rs1_busy, rs2_busy, rd_full, hazard, retire_err;

    // No WB bypass: a register retiring this cycle still reads as busy.
    always_comb begin
        rs1_busy   = dec_uses_rs1 && (dec_read_sel1 != 5'd0) && (cnt_q[dec_read_sel1] != '0);
        rs2_busy   = dec_uses_rs2 && (dec_read_sel2 != 5'd0) && (cnt_q[dec_read_sel2] != '0);
        rd_full    = dec_is_wb && (dec_write_sel != 5'd0) && (cnt_q[dec_write_sel] == CNT_MAX);
        hazard     = rs1_busy || rs2_busy || rd_full;
        d_issue    = fd_valid && a_ready && (state_q == RUN) && !hazard;
        d_stall    = fd_valid && a_ready && !d_issue;
        retire_err = w_regfile && (sel_regfile != 5'd0) && (cnt_q[sel_regfile] == '0);
    end

    always_comb begin
        logic inc, dec;
        cnt_d[0] = '0;
        for (int r = 1; r < 32; r++) begin
            inc      = d_issue && dec_is_wb && (dec_write_sel == 5'(r));
            dec      = w_regfile && (sel_regfile == 5'(r)) && (cnt_q[r] != '0);
            cnt_d[r] = cnt_q[r];
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    // Branch timeout is a down-counter loaded on entry to BR_WAIT; terminal count is 1.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        flush_d = 1'b0;
        err_d   = err_q || retire_err;
        case (state_q)
            RUN: begin
                if (br_resolve) begin
                    err_d = 1'b1;
                end
                if (d_issue && dec_is_branch) begin
                    state_d = BR_WAIT;
                    tmo_d   = TMO_LOAD;
                end
            end
            BR_WAIT: begin
                if (br_resolve) begin
                    if (br_taken) begin
                        state_d = FLUSH;
                        flush_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else if (tmo_q <= TMO_W'(1)) begin
                    err_d   = 1'b1;
                    state_d = RUN;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            tmo_q   <= '0;
            flush_q <= 1'b0;
            err_q   <= 1'b0;
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            flush_q <= flush_d;
            err_q   <= err_d;
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int r = 1; r < 32; r++) begin
            busy_mask[r] = (cnt_q[r] != '0);
        end
    end

    assign d_flush    = flush_q;
    assign ctrl_state = state_q;
    assign sb_err     = err_q;

endmodule

// File: tb/tb_d_issue_ctrl.sv
// Scoreboard bench for d_issue_ctrl: a driver pushes expected outputs from a
// behavioural model each cycle, and a monitor pops and compares them.
module tb_d_issue_ctrl;

    localparam int CNT_W      = 2;
    localparam int BR_TIMEOUT = 15;
    localparam int MAXC       = (1 << CNT_W) - 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fd_valid = 1'b0, dec_uses_rs1 = 1'b0, dec_uses_rs2 = 1'b0;
    logic        dec_is_wb = 1'b0, dec_is_branch = 1'b0, a_ready = 1'b0;
    logic        w_regfile = 1'b0, br_resolve = 1'b0, br_taken = 1'b0;
    logic [4:0]  dec_read_sel1 = '0, dec_read_sel2 = '0, dec_write_sel = '0, sel_regfile = '0;
    logic        d_issue, d_stall, d_flush, sb_err;
    logic [31:0] busy_mask;
    logic [1:0]  ctrl_state;

    d_issue_ctrl #(.CNT_W(CNT_W), .BR_TIMEOUT(BR_TIMEOUT)) dut (
        .clock(clock), .reset(reset), .fd_valid(fd_valid),
        .dec_read_sel1(dec_read_sel1), .dec_read_sel2(dec_read_sel2),
        .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
        .dec_write_sel(dec_write_sel), .dec_is_wb(dec_is_wb), .dec_is_branch(dec_is_branch),
        .a_ready(a_ready), .w_regfile(w_regfile), .sel_regfile(sel_regfile),
        .br_resolve(br_resolve), .br_taken(br_taken),
        .d_issue(d_issue), .d_stall(d_stall), .d_flush(d_flush),
        .busy_mask(busy_mask), .ctrl_state(ctrl_state), .sb_err(sb_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] id;
        logic        issue;
        logic        stall;
        logic        flush;
        logic [31:0] busy;
        logic [1:0]  st;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_id = 0;

    // Reference model: mode 0=RUN 1=BR_WAIT 2=FLUSH, plain integer counters.
    int m_cnt[32];
    int m_mode;
    int m_wait;
    bit m_err;

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_mode = 0;
        m_wait = 0;
        m_err  = 1'b0;
    endfunction

    function automatic bit model_issue();
        bit hz;
        hz = (dec_uses_rs1 && dec_read_sel1 != 0 && m_cnt[dec_read_sel1] > 0) ||
             (dec_uses_rs2 && dec_read_sel2 != 0 && m_cnt[dec_read_sel2] > 0) ||
             (dec_is_wb && dec_write_sel != 0 && m_cnt[dec_write_sel] >= MAXC);
        return fd_valid && a_ready && (m_mode == 0) && !hz;
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        bit   iss;
        iss     = model_issue();
        e.id    = step_id;
        e.issue = iss;
        e.stall = fd_valid && a_ready && !iss;
        e.flush = (m_mode == 2);
        e.busy  = '0;
        for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) e.busy[r] = 1'b1;
        e.st    = 2'(m_mode);
        e.err   = m_err;
        return e;
    endfunction

    function automatic void model_advance();
        bit iss, retire;
        iss    = model_issue();
        retire = 1'b0;
        if (w_regfile && sel_regfile != 0) begin
            if (m_cnt[sel_regfile] == 0) m_err = 1'b1;
            else retire = 1'b1;
        end
        if (iss && dec_is_wb && dec_write_sel != 0) m_cnt[dec_write_sel]++;
        if (retire) m_cnt[sel_regfile]--;
        case (m_mode)
            0: begin
                if (br_resolve) m_err = 1'b1;
                if (iss && dec_is_branch) begin
                    m_mode = 1;
                    m_wait = 0;
                end
            end
            1: begin
                if (br_resolve) begin
                    m_mode = br_taken ? 2 : 0;
                end else begin
                    m_wait++;
                    if (m_wait == BR_TIMEOUT) begin
                        m_err  = 1'b1;
                        m_mode = 0;
                    end
                end
            end
            default: m_mode = 0;
        endcase
    endfunction

    task automatic drive_cycle(input logic fv, input logic ar,
                               input logic u1, input logic [4:0] rs1,
                               input logic u2, input logic [4:0] rs2,
                               input logic wb, input logic [4:0] rd, input logic br,
                               input logic wr, input logic [4:0] wsel,
                               input logic res, input logic tk);
        @(negedge clock);
        reset         = 1'b1;
        fd_valid      = fv;   a_ready       = ar;
        dec_uses_rs1  = u1;   dec_read_sel1 = rs1;
        dec_uses_rs2  = u2;   dec_read_sel2 = rs2;
        dec_is_wb     = wb;   dec_write_sel = rd;   dec_is_branch = br;
        w_regfile     = wr;   sel_regfile   = wsel;
        br_resolve    = res;  br_taken      = tk;
        step_id++;
        exp_q.push_back(model_expect());
        model_advance();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0,0, 0,0, 0,0, 0,0, 0, 0,0, 0,0);
    endtask

    // Reset is asserted between clock edges; the check lands before the next posedge.
    task automatic do_reset();
        @(negedge clock);
        #1;
        reset = 1'b0;
        fd_valid = 0; a_ready = 0; dec_uses_rs1 = 0; dec_uses_rs2 = 0;
        dec_is_wb = 0; dec_is_branch = 0; w_regfile = 0; br_resolve = 0; br_taken = 0;
        dec_read_sel1 = 0; dec_read_sel2 = 0; dec_write_sel = 0; sel_regfile = 0;
        model_reset();
        step_id++;
        exp_q.push_back(model_expect());
        @(negedge clock);
        step_id++;
        exp_q.push_back(model_expect());
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (d_issue !== e.issue || d_stall !== e.stall || d_flush !== e.flush ||
                    busy_mask !== e.busy || ctrl_state !== e.st || sb_err !== e.err) begin
                    n_fail++;
                    $display("FAIL step%0d: got issue=%b stall=%b flush=%b busy=%h state=%b err=%b, expected issue=%b stall=%b flush=%b busy=%h state=%b err=%b",
                             e.id, d_issue, d_stall, d_flush, busy_mask, ctrl_state, sb_err,
                             e.issue, e.stall, e.flush, e.busy, e.st, e.err);
                end
            end
        end
    end

    task automatic random_cycle();
        logic [4:0] wsel;
        logic       wr, res;
        int         busy_regs[$];
        busy_regs.delete();
        for (int r = 1; r < 8; r++) if (m_cnt[r] > 0) busy_regs.push_back(r);
        wr   = ($urandom_range(0, 99) < 40);
        wsel = 5'($urandom_range(1, 7));
        if (busy_regs.size() > 0 && $urandom_range(0, 99) < 95)
            wsel = 5'(busy_regs[$urandom_range(0, busy_regs.size() - 1)]);
        else if (wr && $urandom_range(0, 99) < 85)
            wr = 1'b0;
        res = (m_mode == 1) ? ($urandom_range(0, 99) < 20) : ($urandom_range(0, 99) < 2);
        drive_cycle($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 80,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)),
                    $urandom_range(0, 99) < 10,
                    wr, wsel, res, 1'($urandom_range(0, 1)));
    endtask

    initial begin : driver
        model_reset();
        do_reset();

        // Issue x5 <- x1,x2, then RAW on x5 with WB not bypassed.
        drive_cycle(1,1, 1,5'd1, 1,5'd2, 1,5'd5, 0, 0,5'd0, 0,0);
        drive_cycle(1,1, 1,5'd5, 0,5'd0, 0,5'd0, 0, 0,5'd0, 0,0);
        drive_cycle(1,1, 1,5'd5, 0,5'd0, 0,5'd0, 0, 1,5'd5, 0,0);
        drive_cycle(1,1, 1,5'd5, 0,5'd0, 0,5'd0, 0, 0,5'd0, 0,0);

        // WAW saturation on x7, then simultaneous issue and retire to x7.
        for (int i = 0; i < 4; i++) drive_cycle(1,1, 0,5'd0, 0,5'd0, 1,5'd7, 0, 0,5'd0, 0,0);
        drive_cycle(0,0, 0,5'd0, 0,5'd0, 0,5'd0, 0, 1,5'd7, 0,0);
        drive_cycle(1,1, 0,5'd0, 0,5'd0, 1,5'd7, 0, 1,5'd7, 0,0);
        drive_cycle(0,0, 0,5'd0, 0,5'd0, 0,5'd0, 0, 1,5'd7, 0,0);
        drive_cycle(0,0, 0,5'd0, 0,5'd0, 0,5'd0, 0, 1,5'd7, 0,0);
        idle(1);

        // Taken branch: wait, resolve, one flush cycle, back to RUN.
        drive_cycle(1,1, 1,5'd1, 0,5'd0, 0,5'd0, 1, 0,5'd0, 0,0);
        drive_cycle(1,1, 0,5'd0, 0,5'd0, 1,5'd3, 0, 0,5'd0, 0,0);
        drive_cycle(1,1, 0,5'd0, 0,5'd0, 1,5'd3, 0, 0,5'd0, 1,1);
        drive_cycle(1,1, 0,5'd0, 0,5'd0, 1,5'd3, 0, 0,5'd0, 0,0);
        drive_cycle(1,1, 0,5'd0, 0,5'd0, 1,5'd3, 0, 0,5'd0, 0,0);
        drive_cycle(0,0, 0,5'd0, 0,5'd0, 0,5'd0, 0, 1,5'd3, 0,0);

        // Not-taken branch, then a branch that times out.
        drive_cycle(1,1, 0,5'd0, 0,5'd0, 0,5'd0, 1, 0,5'd0, 0,0);
        drive_cycle(0,0, 0,5'd0, 0,5'd0, 0,5'd0, 0, 0,5'd0, 1,0);
        drive_cycle(1,1, 0,5'd0, 0,5'd0, 0,5'd0, 1, 0,5'd0, 0,0);
        idle(BR_TIMEOUT + 2);

        // Retire to an idle register sets the sticky error.
        do_reset();
        drive_cycle(0,0, 0,5'd0, 0,5'd0, 0,5'd0, 0, 1,5'd9, 0,0);
        idle(2);

        // Asynchronous reset while waiting on a branch with writes in flight.
        drive_cycle(1,1, 0,5'd0, 0,5'd0, 1,5'd3, 0, 0,5'd0, 0,0);
        drive_cycle(1,1, 0,5'd0, 0,5'd0, 1,5'd4, 1, 0,5'd0, 0,0);
        idle(2);
        do_reset();
        idle(1);

        for (int blk = 0; blk < 30; blk++) begin
            do_reset();
            for (int i = 0; i < 60; i++) random_cycle();
        end

        idle(2);
        @(negedge clock);
        @(negedge clock);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
